// File: rtl/eq2_serial_cmp_amisha.sv
// ---------------------------------------------------------------------------
// eq2_serial_cmp_amisha
// Bit-serial unsigned word comparator. Two operands arrive as streams of
// 2-bit digit pairs, most significant digit first, one pair per accepted
// beat. After DIGITS accepted beats the block reports A==B, A>B or A<B.
//
// Handshake: a digit pair is accepted on a rising edge where
// valid_amisha=1 and ready_amisha=1. ready_amisha is 1 only while a word is
// being shifted in, so valid_amisha outside a word is ignored. Cycles with
// valid_amisha=0 inside a word are gaps and change nothing.
//
// Ports:
//   clk_amisha    in   clock, rising edge
//   rst_amisha    in   synchronous active-high reset
//   start_amisha  in   begin a new word (honoured in IDLE or DONE only)
//   valid_amisha  in   a_amisha/b_amisha carry a digit pair
//   a_amisha      in   operand A digit (MSB-first)
//   b_amisha      in   operand B digit (MSB-first)
//   ready_amisha  out  block accepts a digit pair this cycle
//   busy_amisha   out  comparison in progress
//   done_amisha   out  one-cycle pulse, results just updated
//   aeqb_amisha   out  A == B (held)
//   agtb_amisha   out  A >  B unsigned (held)
//   altb_amisha   out  A <  B unsigned (held)
// ---------------------------------------------------------------------------
module eq2_serial_cmp_amisha #(
   parameter int DIGITS = 4
) (
   input  logic       clk_amisha,
   input  logic       rst_amisha,
   input  logic       start_amisha,
   input  logic       valid_amisha,
   input  logic [1:0] a_amisha,
   input  logic [1:0] b_amisha,
   output logic       ready_amisha,
   output logic       busy_amisha,
   output logic       done_amisha,
   output logic       aeqb_amisha,
   output logic       agtb_amisha,
   output logic       altb_amisha
);

   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          decided_q;
   logic          gt_q;
   logic          lt_q;
   logic          ready_q;
   logic          busy_q;
   logic          done_q;
   logic          aeqb_q;
   logic          agtb_q;
   logic          altb_q;

   logic          digit_gt;
   logic          digit_lt;
   logic          last_beat;
   logic          gt_d;
   logic          lt_d;
   logic          decided_d;

   // Once a differing digit has been seen the more significant result is
   // frozen; later digits are consumed but cannot change it.
   always_comb begin
      digit_gt  = (a_amisha > b_amisha);
      digit_lt  = (a_amisha < b_amisha);
      last_beat = (cnt_q == CW'(DIGITS - 1));
      gt_d      = gt_q | (~decided_q & digit_gt);
      lt_d      = lt_q | (~decided_q & digit_lt);
      decided_d = decided_q | digit_gt | digit_lt;
   end

   always_ff @(posedge clk_amisha) begin
      if (rst_amisha) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         decided_q <= 1'b0;
         gt_q      <= 1'b0;
         lt_q      <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aeqb_q    <= 1'b0;
         agtb_q    <= 1'b0;
         altb_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_amisha) begin
                  state_q   <= S_SHIFT;
                  cnt_q     <= '0;
                  decided_q <= 1'b0;
                  gt_q      <= 1'b0;
                  lt_q      <= 1'b0;
                  ready_q   <= 1'b1;
                  busy_q    <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_SHIFT: begin
               if (valid_amisha) begin
                  gt_q      <= gt_d;
                  lt_q      <= lt_d;
                  decided_q <= decided_d;
                  if (last_beat) begin
                     // Results include the final digit's compare.
                     state_q <= S_DONE;
                     cnt_q   <= '0;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     aeqb_q  <= ~gt_d & ~lt_d;
                     agtb_q  <= gt_d;
                     altb_q  <= lt_d;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ready_amisha = ready_q;
   assign busy_amisha  = busy_q;
   assign done_amisha  = done_q;
   assign aeqb_amisha  = aeqb_q;
   assign agtb_amisha  = agtb_q;
   assign altb_amisha  = altb_q;

endmodule
